// File: rtl/mult_hilo_unit.sv
// ============================================================================
// mult_hilo_unit : iterative shift-add WIDTHxWIDTH multiplier with HI/LO regs
//                  (MULT/MULTU/MFHI/MFLO/MTHI/MTLO). Optional MULT_SIGNED_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module mult_hilo_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             sel_hi,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] result_out
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic                 neg_q, neg_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;

   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   acc_next;
   logic [2*WIDTH-1:0]   product;

   // Only the low accumulator bit shifted out on the final step is never read.
   logic                 unused_bits;

   // Carry of the partial add is kept as the new MSB after the right shift.
   always_comb begin
      sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
      acc_next = {sum, acc_q[WIDTH-1:1]};
      product  = neg_q ? (~acc_next + 1'b1) : acc_next;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      case (state_q)
         ST_RUN: begin
            acc_d = acc_next;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d      = ST_DONE;
               {hi_d, lo_d} = product;
            end
         end

         default: begin
            // IDLE and DONE both accept register writes and a new start.
            if (wr_hi) hi_d = wr_data;
            if (wr_lo) lo_d = wr_data;
            if (start) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               acc_d   = '0;
`ifdef MULT_SIGNED_EN
               if (signed_op) begin
                  a_d   = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
                  b_d   = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
                  neg_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
               end else begin
                  a_d   = op_a;
                  b_d   = op_b;
                  neg_d = 1'b0;
               end
`else
               a_d   = op_a;
               b_d   = op_b;
               neg_d = 1'b0;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

`ifdef MULT_SIGNED_EN
   assign unused_bits = acc_q[0];
`else
   assign unused_bits = acc_q[0] ^ signed_op;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy       = (state_q == ST_RUN);
   assign done       = (state_q == ST_DONE);
   assign hi         = hi_q;
   assign lo         = lo_q;
   assign result_out = sel_hi ? hi_q : lo_q;

endmodule

`default_nettype wire
